// File: rtl/pipeline_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, default address width, wait-counter width.
// No logic; no latency; no backpressure.
// Imported by fetch_wait_counter and if_fetch_ctrl.
package pipeline_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } fetch_state_t;

  localparam int ADDR_W_DEF = 32;

  // Wide enough to hold WAIT_CYCLES, never narrower than one bit.
  function automatic int cnt_width(input int wait_cycles);
    int w;
    w = $clog2(wait_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fetch_wait_counter.sv
// Per-fetch wait-state counter: reload to WAIT_CYCLES, count down to zero, hold.
// Registered, one-cycle update; load wins over decrement.
// Holds its value whenever neither load nor dec is asserted.
module fetch_wait_counter
  import pipeline_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = cnt_width(WAIT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WAIT_CYCLES);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= RELOAD;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF sequencing: wait states per fetch, stall merge, pending branch redirect (opt. IF_FETCH_CTRL_PERF_EN counters).
// Redirect: flush same cycle, Branch_Tacken next cycle, PC at target one cycle later when unstalled.
// mem_stall holds everything incl. a pending redirect; hazard holds IF only in RUN.
module if_fetch_ctrl
  import pipeline_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazard,
  input  logic              mem_stall,
  input  logic              ex_branch_taken,
  input  logic [ADDR_W-1:0] ex_branch_addr,
  output logic              freeze,
  output logic              Branch_Tacken,
  output logic [ADDR_W-1:0] Branch_Address,
  output logic              flush,
  output logic              fetch_valid
`ifdef IF_FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       redirect_count
`endif
);

  fetch_state_t state, state_nxt;
  logic         cnt_load;
  logic         cnt_dec;
  logic         cnt_zero;
  logic         redir_done;
  logic         run_freeze;

  fetch_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Branch_Address <= '0;
    end else if (ex_branch_taken) begin
      Branch_Address <= ex_branch_addr;
    end
  end

  // A fresh branch outranks completing the one already pending.
  assign redir_done = (state == REDIR) && !ex_branch_taken && !mem_stall;

  always_comb begin
    state_nxt = state;
    if (ex_branch_taken) begin
      state_nxt = REDIR;
    end else if (redir_done) begin
      state_nxt = RUN;
    end
  end

  assign run_freeze = mem_stall || hazard || !cnt_zero;

  always_comb begin
    freeze        = run_freeze;
    fetch_valid   = !run_freeze;
    Branch_Tacken = 1'b0;
    case (state)
      REDIR: begin
        freeze        = mem_stall;
        fetch_valid   = 1'b0;
        Branch_Tacken = 1'b1;
      end
      default: ;
    endcase
  end

  assign flush = ex_branch_taken;

  // Wait count keeps draining under hazard: the memory access is already in flight.
  assign cnt_dec  = (state == RUN) && !ex_branch_taken && !mem_stall && !cnt_zero;
  assign cnt_load = redir_done ||
                    ((state == RUN) && !ex_branch_taken && !run_freeze);

`ifdef IF_FETCH_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      if ((state == RUN) && freeze) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (redir_done) begin
        redirect_count <= redirect_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances on shared stimulus,
// checked every cycle against an integer reference model plus directed literal checks.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard;
  logic        mem_stall;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_addr;

  logic        f  [2];
  logic        bt [2];
  logic [31:0] ba [2];
  logic        fl [2];
  logic        fv [2];
`ifdef IF_FETCH_CTRL_PERF_EN
  logic [31:0] sc [2];
  logic [31:0] rc [2];
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.WAIT_CYCLES(2), .ADDR_W(32)) dut2 (
    .clk(clk), .rst(rst), .hazard(hazard), .mem_stall(mem_stall),
    .ex_branch_taken(ex_branch_taken), .ex_branch_addr(ex_branch_addr),
    .freeze(f[0]), .Branch_Tacken(bt[0]), .Branch_Address(ba[0]),
    .flush(fl[0]), .fetch_valid(fv[0])
`ifdef IF_FETCH_CTRL_PERF_EN
    , .stall_cycles(sc[0]), .redirect_count(rc[0])
`endif
  );

  if_fetch_ctrl #(.WAIT_CYCLES(0), .ADDR_W(32)) dut0 (
    .clk(clk), .rst(rst), .hazard(hazard), .mem_stall(mem_stall),
    .ex_branch_taken(ex_branch_taken), .ex_branch_addr(ex_branch_addr),
    .freeze(f[1]), .Branch_Tacken(bt[1]), .Branch_Address(ba[1]),
    .flush(fl[1]), .fetch_valid(fv[1])
`ifdef IF_FETCH_CTRL_PERF_EN
    , .stall_cycles(sc[1]), .redirect_count(rc[1])
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a redirect flag, target and remaining wait cycles per instance.
  int          wc      [2] = '{2, 0};
  bit          m_redir [2];
  logic [31:0] m_addr  [2];
  int          m_wait  [2];
  int unsigned m_stall [2];
  int unsigned m_rcnt  [2];

  function automatic bit exp_freeze(input int k);
    if (m_redir[k]) return mem_stall;
    return mem_stall || hazard || (m_wait[k] > 0);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_redir[k] = 1'b0;
        m_addr[k]  = '0;
        m_wait[k]  = wc[k];
        m_stall[k] = 0;
        m_rcnt[k]  = 0;
      end else begin
        if (!m_redir[k] && exp_freeze(k)) m_stall[k]++;
        if (ex_branch_taken) begin
          m_redir[k] = 1'b1;
          m_addr[k]  = ex_branch_addr;
        end else if (m_redir[k]) begin
          if (!mem_stall) begin
            m_redir[k] = 1'b0;
            m_wait[k]  = wc[k];
            m_rcnt[k]++;
          end
        end else if (!mem_stall) begin
          if (m_wait[k] > 0) m_wait[k]--;
          else if (!hazard) m_wait[k] = wc[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("w%0d_flush", wc[k]),       32'(fl[k]), 32'(ex_branch_taken));
        chk($sformatf("w%0d_tacken", wc[k]),      32'(bt[k]), 32'(m_redir[k]));
        chk($sformatf("w%0d_freeze", wc[k]),      32'(f[k]),  32'(exp_freeze(k)));
        chk($sformatf("w%0d_fetch_valid", wc[k]), 32'(fv[k]), 32'(!m_redir[k] && !exp_freeze(k)));
        chk($sformatf("w%0d_addr", wc[k]),        ba[k],      m_addr[k]);
`ifdef IF_FETCH_CTRL_PERF_EN
        chk($sformatf("w%0d_stall_cycles", wc[k]),   sc[k], m_stall[k]);
        chk($sformatf("w%0d_redirect_count", wc[k]), rc[k], m_rcnt[k]);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit t1_pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    rst = 1'b1; hazard = 1'b0; mem_stall = 1'b0;
    ex_branch_taken = 1'b0; ex_branch_addr = '0;
    repeat (2) step();

    #3;
    chk("rst_freeze_w2", 32'(f[0]),  32'd1);
    chk("rst_tacken_w2", 32'(bt[0]), 32'd0);
    chk("rst_addr_w2",   ba[0],      32'd0);
    chk("rst_fv_w2",     32'(fv[0]), 32'd0);
    chk("rst_freeze_w0", 32'(f[1]),  32'd0);
    step();

    // 1: free-running fetch cadence
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #3;
      chk($sformatf("t1_freeze_%0d", i), 32'(f[0]),  32'(t1_pat[i]));
      chk($sformatf("t1_fv_%0d", i),     32'(fv[0]), 32'(!t1_pat[i]));
      chk($sformatf("t1_fv_w0_%0d", i),  32'(fv[1]), 32'd1);
      step();
    end

    // 2: unstalled branch redirect
    ex_branch_taken = 1'b1; ex_branch_addr = 32'h40;
    #3 chk("t2_flush", 32'(fl[0]), 32'd1);
    step();
    ex_branch_taken = 1'b0; ex_branch_addr = 32'h0;
    #3;
    chk("t2_tacken", 32'(bt[0]), 32'd1);
    chk("t2_addr",   ba[0],      32'h40);
    chk("t2_freeze_n1", 32'(f[0]), 32'd0);
    step();
    #3 chk("t2_freeze_n2", 32'(f[0]), 32'd1);
    step();
    #3 chk("t2_freeze_n3", 32'(f[0]), 32'd1);
    step();

    // 3: branch under a 3-cycle mem_stall, then 4: hazard mid-count
    ex_branch_taken = 1'b1; ex_branch_addr = 32'h80; mem_stall = 1'b1;
    step();
    ex_branch_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #3;
      chk($sformatf("t3_tacken_%0d", i), 32'(bt[0]), 32'd1);
      chk($sformatf("t3_freeze_%0d", i), 32'(f[0]),  32'd1);
      step();
    end
    mem_stall = 1'b0;
    #3;
    chk("t3_done_tacken", 32'(bt[0]), 32'd1);
    chk("t3_done_freeze", 32'(f[0]),  32'd0);
    step();
    #3 chk("t4_freeze_c0", 32'(f[0]), 32'd1);
    step();
    hazard = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3 chk($sformatf("t4_freeze_hz%0d", i), 32'(f[0]), 32'd1);
      step();
    end
    hazard = 1'b0;
    #3 chk("t4_fv_after", 32'(fv[0]), 32'd1);
    step();

    // 5: reset during REDIR
    ex_branch_taken = 1'b1; ex_branch_addr = 32'h123;
    step();
    ex_branch_taken = 1'b0;
    #3 chk("t5_tacken_pre", 32'(bt[0]), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #3;
    chk("t5_tacken", 32'(bt[0]), 32'd0);
    chk("t5_addr",   ba[0],      32'd0);
    chk("t5_freeze", 32'(f[0]),  32'd1);
    chk("t5_fv_w0",  32'(fv[1]), 32'd1);
    step();
    #3 chk("t5_cnt2_freeze", 32'(f[0]), 32'd1);
    step();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rst             = ($urandom_range(0, 99) == 0);
      ex_branch_taken = ($urandom_range(0, 11) == 0);
      ex_branch_addr  = $urandom;
      mem_stall       = ($urandom_range(0, 4) == 0);
      hazard          = ($urandom_range(0, 3) == 0);
      step();
    end
    rst = 1'b0; ex_branch_taken = 1'b0; mem_stall = 1'b0; hazard = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
